twiddle_phase_gen: RTL
======================

TWIDDLE_PHASE_GEN -- requirements
Module: twiddle_phase_gen

Interface
REQ-001 SHALL have parameter LOG2N, default 8, log2 of FFT size N; legal range 4..14.
REQ-002 SHALL have parameter STAGE, default 0, R2²SDF stage-pair index s; sub-FFT size Np = 2^(LOG2N-2*STAGE), which SHALL be >= 4.
REQ-003 SHALL have parameter CORDIC_LAT, default 18, enabled-cycle latency of the downstream sin/cos CORDIC, from phase_in sampled to sin/cos valid.
REQ-004 sys_clk  input  1  clock; all state updates on rising edge.
REQ-005 sys_nrst  input  1  reset, asynchronous, active-low.
REQ-006 sys_en  input  1  global pipeline enable; when 0, all registers hold.
REQ-007 in_valid  input  1  one input sample present this cycle.
REQ-008 in_sop  input  1  start of frame; qualified by in_valid.
REQ-009 phase_out  output  16  twiddle phase for the CORDIC phase_in; 2^16 = 360°.
REQ-010 phase_valid  output  1  phase_out holds a new phase.
REQ-011 tw_valid  output  1  phase_valid delayed CORDIC_LAT enabled cycles; marks valid CORDIC sin/cos.
REQ-012 tw_sop  output  1  in_sop delayed and aligned with tw_valid.
REQ-013 busy  output  1  state is RUN.
REQ-014 sync_err  output  1  sticky flag for a frame misalignment event.

Function
REQ-015 SHALL implement states IDLE and RUN; a sample SHALL be accepted only when sys_en=1 and in_valid=1.
REQ-016 IDLE: accepted sample with in_sop=1 -> RUN, processed as index n=0; accepted sample with in_sop=0 -> ignored, phase_valid=0, stay IDLE.
REQ-017 RUN: each accepted sample takes index n = counter value, then counter increments modulo Np; at n=Np-1 counter wraps to 0 and state stays RUN (back-to-back frames, no sop required).
REQ-018 RUN: accepted in_sop=1 with counter=0 is normal; with counter≠0, the sample SHALL be treated as n=0, counter set to 1, and sync_err set.
REQ-019 Index decomposition: Q = Np/4, quarter q = n / Q, k = n mod Q, multiplier m = {0,2,1,3}[q], exponent e = k*m (no multiplier primitive; shift/add).
REQ-020 phase_out SHALL equal (−(e << (16 − log2 Np))) mod 2^16, exact with no rounding; e << (16 − log2 Np) SHALL never exceed 16 bits.
REQ-021 phase_out and phase_valid SHALL be registered, one enabled cycle after the accepted sample; phase_out holds its last value when phase_valid=0.
REQ-022 phase_valid SHALL be 1 for exactly one cycle per accepted, non-ignored sample (when sys_en stays 1).
REQ-023 tw_valid/tw_sop SHALL come from a CORDIC_LAT-deep shift register of phase_valid/(phase_valid & sop), advanced only when sys_en=1.
REQ-024 sys_en=0 SHALL freeze state, counter, outputs and the delay line; resuming SHALL continue with no loss or duplication.
REQ-025 in_valid=0 cycles SHALL not advance the counter; phase_valid=0 for the next cycle.

Reset
REQ-026 Asynchronous sys_nrst=0 SHALL force: state IDLE, counter 0, phase_out 0x0000, phase_valid 0, tw_valid 0, tw_sop 0, busy 0, sync_err 0, delay line all 0.
REQ-027 Reset mid-frame SHALL abandon the frame; after release, samples are ignored until the next in_sop.
REQ-028 sync_err SHALL clear only on reset.

Verification (LOG2N=4, STAGE=0, CORDIC_LAT=18 unless stated)
REQ-029 Frame n=0..15 continuous with sop at n=0 -> phase_out: n0..3=0x0000; n5=0xE000; n9=0xF000; n15=0x7000; phase_valid one cycle after each sample.
REQ-030 Alignment: sop sample at cycle T -> phase_valid at T+1; tw_valid and tw_sop at T+19; tw_valid pulses total 16.
REQ-031 Samples before first sop -> phase_valid stays 0, busy 0; two back-to-back frames, sop only on first -> second frame phases repeat the first, sync_err 0.
REQ-032 sop injected at n=6 -> that sample phase 0x0000, next sample treated as n=1, sync_err=1 until reset.
REQ-033 sys_en low 5 cycles mid-frame and in_valid gaps -> phase sequence and tw_valid count identical to the uninterrupted run, delay from phase_valid to tw_valid still 18 enabled cycles.
REQ-034 sys_nrst asserted at n=8, released, then new sop frame -> all outputs 0 during reset; new frame restarts at n=0 with correct phases.

Source files
------------

// File: rtl/twiddle_phase_gen.sv
// Twiddle phase generator for an R2^2SDF stage pair: tracks the sample index within
// each Np-point sub-frame and emits the negated CORDIC phase plus delayed valid/sop markers.
module twiddle_phase_gen #(
    parameter int LOG2N      = 8,
    parameter int STAGE      = 0,
    parameter int CORDIC_LAT = 18
) (
    input  logic        sys_clk,
    input  logic        sys_nrst,
    input  logic        sys_en,
    input  logic        in_valid,
    input  logic        in_sop,
    output logic [15:0] phase_out,
    output logic        phase_valid,
    output logic        tw_valid,
    output logic        tw_sop,
    output logic        busy,
    output logic        sync_err
);

    localparam int          LNP = LOG2N - 2 * STAGE;
    localparam int          SH  = 16 - LNP;
    localparam int unsigned LAT = CORDIC_LAT;
    localparam logic [LNP-1:0] K_MASK = LNP'((1 << (LNP - 2)) - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [LNP-1:0]      cnt;
    logic [LNP-1:0]      n_idx;
    logic [LNP-1:0]      k;
    logic [LNP-1:0]      e;
    logic [1:0]          q;
    logic [15:0]         phase_nxt;
    logic                accept;
    logic                phase_sop;
    logic [LAT-1:0]      dl_valid;
    logic [LAT-1:0]      dl_sop;

    assign accept   = sys_en & in_valid;
    assign busy     = (state == RUN);
    assign tw_valid = dl_valid[LAT-1];
    assign tw_sop   = dl_sop[LAT-1];

    // A sop always restarts at index 0, so the phase is computed from 0 in that case.
    // e = k*m with m in {0,2,1,3}; 3k < Np, so e always fits in LNP bits.
    always_comb begin
        n_idx = in_sop ? '0 : cnt;
        q     = n_idx[LNP-1 -: 2];
        k     = n_idx & K_MASK;
        unique case (q)
            2'd0:    e = '0;
            2'd1:    e = k << 1;
            2'd2:    e = k;
            default: e = k + (k << 1);
        endcase
        phase_nxt = 16'd0 - (16'(e) << SH);
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state       <= IDLE;
            cnt         <= '0;
            phase_out   <= '0;
            phase_valid <= 1'b0;
            phase_sop   <= 1'b0;
            sync_err    <= 1'b0;
            dl_valid    <= '0;
            dl_sop      <= '0;
        end else if (sys_en) begin
            phase_valid <= 1'b0;
            phase_sop   <= 1'b0;
            dl_valid[0] <= phase_valid;
            dl_sop[0]   <= phase_valid & phase_sop;
            for (int unsigned i = 1; i < LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_sop[i]   <= dl_sop[i-1];
            end
            if (accept) begin
                if (in_sop) begin
                    if (state == RUN && cnt != '0)
                        sync_err <= 1'b1;
                    state       <= RUN;
                    cnt         <= LNP'(1);
                    phase_out   <= phase_nxt;
                    phase_valid <= 1'b1;
                    phase_sop   <= 1'b1;
                end else if (state == RUN) begin
                    cnt         <= cnt + LNP'(1);
                    phase_out   <= phase_nxt;
                    phase_valid <= 1'b1;
                end
            end
        end
    end

endmodule
